cfu_mul_seq: RTL and testbench
==============================

Name: cfu_mul_seq

Overview:
- Multi-cycle CFU controller that sequences a pipelined signed multiplier and adds a 32-bit accumulator plus a runtime shift register.
- Replaces the always-ready combinational CFU handshake with a true valid/ready protocol on both the cmd and rsp channels.
- Sits directly on the CPU CFU port.
- One command in flight at a time; the multiplier latency is hidden behind the handshake.

Parameters:
- MUL_LATENCY, 2, multiplier pipeline depth in cycles; legal range 1..4.
- SHIFT_RESET, 10, reset value of the arithmetic shift amount.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_payload_function_id  in  10  bits [2:0] select the op; bits [9:3] ignored
- cmd_payload_inputs_0  in  32  operand A / config value
- cmd_payload_inputs_1  in  32  operand B
- rsp_valid  out  1  response available
- rsp_ready  in  1  CPU accepts the response
- rsp_payload_outputs_0  out  32  result

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset); it is sampled on the rising edge of clk.
- Reset values:
  - state = IDLE, cmd_ready = 1, rsp_valid = 0, rsp_payload_outputs_0 = 0.
  - acc = 0, shamt = SHIFT_RESET.
  - Multiplier pipeline valid bits cleared.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid, latch function_id[2:0] and both operands.
    - Ops 0–2 go to MUL and the counter loads MUL_LATENCY-1.
    - All other ops go to RESP with the result registered in that same edge.
  - MUL: cmd_ready = 0. The counter decrements each cycle. When the counter is 0 and the multiplier output is valid, compute the result and go to RESP.
  - RESP: rsp_valid = 1 and the payload is held stable until rsp_ready. On rsp_ready, go to IDLE.
    - cmd_ready stays 0 in RESP, so there is no same-cycle back-to-back acceptance.
    - Command-to-response latency: MUL_LATENCY+1 cycles for mul ops, 1 cycle for the others.
- Ops (P = full 64-bit signed product A*B):
  - 0 MULSH: result = (P >>> shamt)[31:0].
  - 1 MUL: result = P[31:0].
  - 2 MAC: acc <= acc + (P >>> shamt)[31:0] with 32-bit wrap; result = new acc. acc updates on the MUL→RESP edge.
  - 3 RDACC: result = acc.
  - 4 CLRACC: result = old acc; acc <= 0.
  - 5 SETSH: shamt <= A[5:0]; result = previous shamt, zero-extended.
  - 6, 7: result = 0; no side effects.
- Boundary conditions:
  - shamt range is 0..63. shamt = 0 gives MULSH == MUL.
  - Operand or function_id changes while cmd_ready = 0 are ignored.
  - rsp_ready held high before rsp_valid has no effect.
  - rsp_ready low holds the response indefinitely; acc is not modified again while the response waits.
- Reset mid-operation (MUL or RESP): the command is abandoned and no response is issued. acc and shamt return to their reset values.

Optional Feature:
- Macro: CFU_MAC_SATURATE_EN.
- Defined: MAC computes a 33-bit sum and clamps to 0x7FFFFFFF or 0x80000000 on signed overflow. A sticky sat flag is set on clamp. Read it as RDACC with A[0] = 1 (result = {31'b0, sat}); CLRACC clears it.
- Undefined: MAC wraps modulo 2^32; A is ignored by RDACC; no flag logic is present.

Decomposition:
- Package cfu_mul_pkg holds:
  - op enum: OP_MULSH, OP_MUL, OP_MAC, OP_RDACC, OP_CLRACC, OP_SETSH.
  - state enum: IDLE, MUL, RESP.
  - constant SHAMT_W = 6.
- Sub-module cfu_mul_pipe: a MUL_LATENCY-stage registered signed 32x32→64 multiplier with an in_valid/out_valid shift chain, cleared by reset. The controller owns the FSM, acc, shamt and response register.

Test Plan:
- Reset, then MUL A=3, B=-4 → cmd_ready drops for 3 cycles; rsp_valid with 0xFFFFFFF4; shamt reads back 10 via SETSH.
- MULSH A=-3000, B=1000 at shamt 10 → 0xFFFFF48E (floor of -2929.69). Then SETSH A=0 returns 10; MULSH A=5, B=7 → 35.
- MAC sequence (2,3), (4,5) at shamt 0 → responses 6 then 26; RDACC → 26; CLRACC → 26; RDACC → 0.
- Backpressure: rsp_ready held low 5 cycles during MAC → payload stable, cmd_ready = 0, acc incremented exactly once; release → next command accepted one cycle later.
- Overflow at shamt 0: MAC 0x40000000*1 twice → 0x80000000 without the macro; with CFU_MAC_SATURATE_EN → 0x7FFFFFFF, and RDACC A=1 → 1.
- Assert reset during MUL state → no rsp_valid; RDACC → 0; MULSH A=1024, B=1024 → 1024 (shamt back to 10).

Source files
------------

// File: rtl/cfu_mul_pkg.sv
// cfu_mul_pkg: op codes, controller states and shift helper for the sequenced CFU multiplier.
package cfu_mul_pkg;
   localparam int SHAMT_W = 6;
   typedef enum logic [2:0] {
      OP_MULSH  = 3'd0,
      OP_MUL    = 3'd1,
      OP_MAC    = 3'd2,
      OP_RDACC  = 3'd3,
      OP_CLRACC = 3'd4,
      OP_SETSH  = 3'd5
   } op_t;
   typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;
   function automatic logic [31:0] asr_lo(input logic signed [63:0] p, input logic [SHAMT_W-1:0] sh);
      return 32'(p >>> sh);
   endfunction
endpackage

// File: rtl/cfu_mul_pipe.sv
// cfu_mul_pipe: MUL_LATENCY-stage registered signed 32x32->64 multiplier with a valid shift chain.
module cfu_mul_pipe #(
   parameter int MUL_LATENCY = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   input  logic signed [31:0] a,
   input  logic signed [31:0] b,
   output logic               out_valid,
   output logic signed [63:0] p
);
   logic signed [63:0]     prod [MUL_LATENCY];
   logic [MUL_LATENCY-1:0] vld;
   always_ff @(posedge clk) begin
      prod[0] <= $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      for (int i = 1; i < MUL_LATENCY; i++) prod[i] <= prod[i-1];
   end
   always_ff @(posedge clk) begin
      if (reset) vld <= '0;
      else begin
         vld[0] <= in_valid;
         for (int i = 1; i < MUL_LATENCY; i++) vld[i] <= vld[i-1];
      end
   end
   assign out_valid = vld[MUL_LATENCY-1];
   assign p         = prod[MUL_LATENCY-1];
endmodule

// File: rtl/cfu_mul_seq.sv
// cfu_mul_seq: valid/ready CFU controller sequencing a pipelined multiplier, accumulator and shift register.
// Define CFU_MAC_SATURATE_EN for saturating MAC with a sticky sat flag readable via RDACC A[0]=1.
module cfu_mul_seq
   import cfu_mul_pkg::*;
#(
   parameter int MUL_LATENCY = 2,
   parameter int SHIFT_RESET = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_payload_function_id,
   input  logic [31:0] cmd_payload_inputs_0,
   input  logic [31:0] cmd_payload_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_payload_outputs_0
);
   state_t             state, state_n;
   logic [2:0]         f, op_q, cnt;
   logic [31:0]        acc, acc_n, res_n, shifted, mac_sum, rd_val;
   logic [SHAMT_W-1:0] shamt, shamt_n;
   logic               accept, is_mul, pv, done, unused_bits;
   logic signed [63:0] prod;
   assign f           = cmd_payload_function_id[2:0];
   assign unused_bits = ^cmd_payload_function_id[9:3];
   assign accept      = state == IDLE && cmd_valid;
   assign is_mul      = f <= OP_MAC;
   assign cmd_ready   = state == IDLE;
   assign rsp_valid   = state == RESP;
   assign done        = state == MUL && cnt == '0 && pv;
   assign shifted     = asr_lo(prod, shamt);
   cfu_mul_pipe #(.MUL_LATENCY(MUL_LATENCY)) u_pipe (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (accept && is_mul),
      .a         (cmd_payload_inputs_0),
      .b         (cmd_payload_inputs_1),
      .out_valid (pv),
      .p         (prod)
   );
`ifdef CFU_MAC_SATURATE_EN
   logic        sat, ovf;
   logic [32:0] sum;
   assign sum     = {acc[31], acc} + {shifted[31], shifted};
   assign ovf     = sum[32] ^ sum[31];
   assign mac_sum = ovf ? (sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum[31:0];
   assign rd_val  = cmd_payload_inputs_0[0] ? {31'b0, sat} : acc;
   always_ff @(posedge clk) begin
      if (reset) sat <= 1'b0;
      else if (done && op_q == OP_MAC && ovf) sat <= 1'b1;
      else if (accept && f == OP_CLRACC) sat <= 1'b0;
   end
`else
   assign mac_sum = acc + shifted;
   assign rd_val  = acc;
`endif
   always_comb begin
      state_n = state;
      acc_n   = acc;
      shamt_n = shamt;
      res_n   = rsp_payload_outputs_0;
      case (state)
         IDLE: if (cmd_valid) begin
            state_n = is_mul ? MUL : RESP;
            res_n   = f == OP_RDACC ? rd_val : f == OP_CLRACC ? acc : f == OP_SETSH ? 32'(shamt) : '0;
            if (f == OP_CLRACC) acc_n = '0;
            if (f == OP_SETSH) shamt_n = cmd_payload_inputs_0[SHAMT_W-1:0];
         end
         MUL: if (done) begin
            state_n = RESP;
            res_n   = op_q == OP_MUL ? prod[31:0] : op_q == OP_MAC ? mac_sum : shifted;
            if (op_q == OP_MAC) acc_n = mac_sum;
         end
         RESP: if (rsp_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state                 <= IDLE;
         acc                   <= '0;
         shamt                 <= SHAMT_W'(SHIFT_RESET);
         rsp_payload_outputs_0 <= '0;
         op_q                  <= '0;
         cnt                   <= '0;
      end else begin
         state                 <= state_n;
         acc                   <= acc_n;
         shamt                 <= shamt_n;
         rsp_payload_outputs_0 <= res_n;
         if (accept) op_q <= f;
         cnt <= accept ? 3'(MUL_LATENCY - 1) : cnt - 3'(cnt != '0);
      end
   end
endmodule

// File: tb/tb_cfu_mul_seq.sv
// tb_cfu_mul_seq: directed plus random commands scored against an arithmetic model of the CFU ops.
module tb_cfu_mul_seq;
   localparam int L = 2;
   logic        clk = 0, reset = 1, cmd_valid = 0, rsp_ready = 0;
   logic        cmd_ready, rsp_valid;
   logic [9:0]  fid = '0;
   logic [31:0] in0 = '0, in1 = '0, out0;
   int          errors = 0, checks = 0;
   logic [31:0] m_acc;
   logic [5:0]  m_sh;
   logic        m_sat;
   always #5 clk = ~clk;
   cfu_mul_seq #(.MUL_LATENCY(L), .SHIFT_RESET(10)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .cmd_payload_function_id (fid),
      .cmd_payload_inputs_0    (in0),
      .cmd_payload_inputs_1    (in1),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_payload_outputs_0   (out0)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint p, s;
      logic [31:0] lo, r;
      p  = longint'($signed(a)) * longint'($signed(b));
      s  = p >>> m_sh;
      lo = s[31:0];
      r  = '0;
      case (f)
         3'd0: r = lo;
         3'd1: r = p[31:0];
         3'd2: begin
            s = longint'($signed(m_acc)) + longint'($signed(lo));
`ifdef CFU_MAC_SATURATE_EN
            if (s > 64'sd2147483647) begin m_acc = 32'h7FFF_FFFF; m_sat = 1; end
            else if (s < -64'sd2147483648) begin m_acc = 32'h8000_0000; m_sat = 1; end
            else m_acc = s[31:0];
`else
            m_acc = s[31:0];
`endif
            r = m_acc;
         end
`ifdef CFU_MAC_SATURATE_EN
         3'd3: r = a[0] ? {31'b0, m_sat} : m_acc;
`else
         3'd3: r = m_acc;
`endif
         3'd4: begin r = m_acc; m_acc = '0; m_sat = 0; end
         3'd5: begin r = {26'b0, m_sh}; m_sh = a[5:0]; end
         default: r = '0;
      endcase
      return r;
   endfunction
   task automatic do_reset();
      reset = 1; cmd_valid = 0; rsp_ready = 0;
      @(posedge clk); #1;
      reset = 0;
      m_acc = '0; m_sh = 6'd10; m_sat = 0;
   endtask
   task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] exp;
      int n;
      exp = model(f, a, b);
      check("ready", cmd_ready, 1);
      cmd_valid = 1; fid = {7'($urandom), f}; in0 = a; in1 = b; rsp_ready = (hold == 0);
      @(posedge clk); #1;
      cmd_valid = 0; fid = 10'($urandom); in0 = $urandom; in1 = $urandom;
      n = 1;
      while (!rsp_valid && n < 16) begin
         check("busy", cmd_ready, 0);
         @(posedge clk); #1;
         n++;
      end
      check("latency", n, f <= 3'd2 ? L + 1 : 1);
      check($sformatf("op%0d", f), out0, exp);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", rsp_valid, 1);
         check("hold_data", out0, exp);
         check("hold_ready", cmd_ready, 0);
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      check("released", {rsp_valid, cmd_ready}, 2'b01);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", cmd_ready, 1);
      check("rst_valid", rsp_valid, 0);
      check("rst_data", out0, 0);
      do_reset();
      run(3'd1, 32'd3, -32'sd4, 0);
      check("mul_neg", out0, 32'hFFFF_FFF4);
      run(3'd5, 32'd10, 0, 0);
      run(3'd0, -32'sd3000, 32'd1000, 0);
      run(3'd5, 32'd0, 0, 0);
      run(3'd0, 32'd5, 32'd7, 0);
      run(3'd2, 32'd2, 32'd3, 0);
      run(3'd2, 32'd4, 32'd5, 5);
      run(3'd3, 32'd0, 0, 0);
      run(3'd4, 32'd0, 0, 0);
      run(3'd3, 32'd0, 0, 0);
      run(3'd2, 32'h4000_0000, 32'd1, 0);
      run(3'd2, 32'h4000_0000, 32'd1, 2);
      run(3'd3, 32'd1, 0, 0);
      run(3'd6, 32'd9, 32'd9, 0);
      run(3'd7, 32'd9, 32'd9, 1);
      cmd_valid = 1; fid = 10'd1; in0 = 32'd7; in1 = 32'd9; rsp_ready = 1;
      @(posedge clk); #1;
      cmd_valid = 0;
      check("mid_busy", cmd_ready, 0);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         check("mid_norsp", rsp_valid, 0);
         @(posedge clk); #1;
      end
      run(3'd3, 32'd0, 0, 0);
      run(3'd0, 32'd1024, 32'd1024, 0);
      cmd_valid = 1; fid = 10'd3; in0 = 32'd0; rsp_ready = 0;
      @(posedge clk); #1;
      cmd_valid = 0;
      check("resp_pending", rsp_valid, 1);
      do_reset();
      check("resp_abandon", rsp_valid, 0);
      for (int i = 0; i < 80; i++)
         run(3'($urandom_range(0, 7)), $urandom, $urandom, ($urandom % 2) * $urandom_range(0, 3));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
